pcm_sample_fifo: RTL and testbench

Sample buffer between the PDM peripheral's CIC3 decimation filter and the TinyQV register interface. Accepts one 16-bit PCM word per filter strobe, holds up to DEPTH samples so the CPU can drain audio in bursts instead of once per sample, and raises a level-threshold interrupt. Sticky overflow and underflow flags record lost or invalid transfers.

---
 rtl/pcm_sample_fifo_if.sv | 30 +++
 rtl/pcm_sample_fifo.sv | 73 +++++++
 tb/tb_pcm_sample_fifo.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/pcm_sample_fifo_if.sv
// Handshake/status bundle between the CIC3 decimator, the PCM sample FIFO and the register block.
// LW must equal $clog2(DEPTH)+1 of the attached FIFO.
interface pcm_sample_fifo_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LW    = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             rd_en;
    logic             flush;
    logic             flag_clr;
    logic [LW-1:0]    threshold;
    logic [WIDTH-1:0] rd_data;
    logic [LW-1:0]    level;
    logic             empty;
    logic             full;
    logic             irq;
    logic             overflow;
    logic             underflow;

    modport master (
        output in_valid, in_data, rd_en, flush, flag_clr, threshold,
        input  rd_data, level, empty, full, irq, overflow, underflow
    );

    modport slave (
        input  in_valid, in_data, rd_en, flush, flag_clr, threshold,
        output rd_data, level, empty, full, irq, overflow, underflow
    );
endinterface

// File: rtl/pcm_sample_fifo.sv
// PCM sample FIFO: buffers decimated audio words for burst CPU reads, with a level
// threshold interrupt and sticky overflow/underflow flags.
module pcm_sample_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    pcm_sample_fifo_if.slave   s_bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             r_overflow;
    logic             r_underflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_ovf_set;
    logic w_udf_set;
    logic w_clear;

    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == LW'(DEPTH));
    assign w_clear   = rst | s_bus.flush;
    assign w_pop     = s_bus.rd_en & ~w_empty;
    // A full FIFO still accepts a sample when a pop frees a slot in the same cycle.
    assign w_push    = s_bus.in_valid & (~w_full | w_pop);
    assign w_ovf_set = s_bus.in_valid & ~w_push;
    assign w_udf_set = s_bus.rd_en & w_empty;

    // Pointers, level and sticky flags; reset and flush share one clear path.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            r_overflow  <= w_ovf_set | (r_overflow  & ~s_bus.flag_clr);
            r_underflow <= w_udf_set | (r_underflow & ~s_bus.flag_clr);
        end
    end

    // Sample storage is never cleared; emptiness masks stale contents.
    always_ff @(posedge clk) begin
        if (!w_clear && w_push) begin
            r_mem[r_wptr] <= s_bus.in_data;
        end
    end

    assign s_bus.rd_data   = w_empty ? '0 : r_mem[r_rptr];
    assign s_bus.level     = r_level;
    assign s_bus.empty     = w_empty;
    assign s_bus.full      = w_full;
    assign s_bus.irq       = (s_bus.threshold != '0) && (r_level >= s_bus.threshold);
    assign s_bus.overflow  = r_overflow;
    assign s_bus.underflow = r_underflow;
endmodule

// File: tb/tb_pcm_sample_fifo.sv
// Scoreboard bench for pcm_sample_fifo: a queue model predicts pop data, level and flags.
module tb_pcm_sample_fifo;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned LW    = 4;

    logic clk;
    logic rst;

    pcm_sample_fifo_if #(.WIDTH(WIDTH), .LW(LW)) bus ();

    pcm_sample_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .s_bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned      n_checks = 0;
    int unsigned      n_errors = 0;
    logic [WIDTH-1:0] sb_q[$];
    logic             m_ovf;
    logic             m_udf;
    logic [LW-1:0]    thr;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Compare every visible output against the model; called away from the rising edge.
    task automatic check_state(input string tag);
        int unsigned lvl;
        logic [WIDTH-1:0] head;
        lvl  = sb_q.size();
        head = (lvl != 0) ? sb_q[0] : '0;
        check_val({tag, ".level"},     32'(bus.level),     32'(lvl));
        check_val({tag, ".empty"},     32'(bus.empty),     32'(lvl == 0));
        check_val({tag, ".full"},      32'(bus.full),      32'(lvl == DEPTH));
        check_val({tag, ".irq"},       32'(bus.irq),       32'((thr != 0) && (lvl >= 32'(thr))));
        check_val({tag, ".overflow"},  32'(bus.overflow),  32'(m_ovf));
        check_val({tag, ".underflow"}, 32'(bus.underflow), 32'(m_udf));
        check_val({tag, ".rd_data"},   32'(bus.rd_data),   32'(head));
    endtask

    // One clock: drive at the falling edge, check popped data, advance the model.
    task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic r,
                       input logic fl, input logic fc);
        bit pop, push, ovf_set, udf_set;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.rd_en     = r;
        bus.flush     = fl;
        bus.flag_clr  = fc;
        bus.threshold = thr;
        #1;
        if (r && sb_q.size() != 0 && !fl)
            check_val("pop_data", 32'(bus.rd_data), 32'(sb_q[0]));
        if (fl) begin
            sb_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            pop     = r && (sb_q.size() != 0);
            push    = v && ((sb_q.size() < DEPTH) || pop);
            ovf_set = v && !push;
            udf_set = r && (sb_q.size() == 0);
            if (pop)  void'(sb_q.pop_front());
            if (push) sb_q.push_back(d);
            m_ovf = ovf_set | (m_ovf & ~fc);
            m_udf = udf_set | (m_udf & ~fc);
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.rd_en    = 1'b0;
        bus.flush    = 1'b0;
        bus.flag_clr = 1'b0;
    endtask

    task automatic push_n(input int n, input logic [WIDTH-1:0] base);
        for (int i = 0; i < n; i++) cyc(1'b1, base + WIDTH'(i), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_n(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        thr   = '0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            bus.in_valid  = 1'($urandom);
            bus.in_data   = WIDTH'($urandom);
            bus.rd_en     = 1'($urandom);
            bus.flush     = 1'($urandom);
            bus.flag_clr  = 1'($urandom);
            bus.threshold = LW'($urandom);
            @(negedge clk);
        end
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.rd_en     = 1'b0;
        bus.flush     = 1'b0;
        bus.flag_clr  = 1'b0;
        bus.threshold = thr;
        #1;
        check_state("reset");

        // Fill/drain three times so both pointers wrap.
        for (int k = 0; k < 3; k++) begin
            push_n(DEPTH, 16'h0001);
            check_state("fill");
            pop_n(DEPTH);
            check_state("drain");
        end

        // Overflow drops the new sample and keeps stored ones.
        push_n(DEPTH, 16'hA000);
        cyc(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
        check_state("ovf");
        pop_n(DEPTH);
        check_state("ovf_drain");
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_state("ovf_clr");

        // Full: push and pop together both succeed.
        push_n(DEPTH, 16'hC000);
        cyc(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
        check_state("full_pp");
        pop_n(DEPTH);
        check_state("full_pp_drain");

        // Empty: pop flags underflow, push still lands.
        cyc(1'b1, 16'h5678, 1'b1, 1'b0, 1'b0);
        check_state("empty_pp");
        pop_n(1);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check_state("udf_vs_clr");
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        check_state("udf_clr");

        // Threshold interrupt.
        thr = LW'(4);
        push_n(3, 16'h3000);
        check_state("thr3");
        push_n(1, 16'h3003);
        check_state("thr4");
        pop_n(1);
        check_state("thr_pop");
        push_n(3, 16'h3100);
        check_state("lvl6");
        thr = '0;
        bus.threshold = thr;
        #1;
        check_state("thr0");
        thr = LW'(9);
        bus.threshold = thr;
        #1;
        check_state("thr9");

        // Flush beats push, pop and flag set.
        pop_n(int'(sb_q.size()));
        push_n(DEPTH, 16'hD000);
        cyc(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
        pop_n(3);
        check_state("pre_flush");
        cyc(1'b1, 16'hF00D, 1'b1, 1'b1, 1'b0);
        check_state("flush");

        // Random traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            if ((i % 50) == 0) thr = LW'($urandom_range(0, DEPTH + 1));
            cyc(1'($urandom), WIDTH'($urandom), 1'($urandom),
                ($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0));
            check_state("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
